// File: rtl/adc366x_pkg.sv
// Shared types and constants for the ADC366x IDELAY training controller.
package adc366x_pkg;

  localparam int TAP_W   = 5;
  localparam int LANES   = 5;
  localparam int DLY_W   = LANES * TAP_W + 1;
  localparam int TGL_BIT = DLY_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_NEXT,
    ST_EVAL,
    ST_APPLY,
    ST_DONE
  } state_t;

  function automatic logic [LANES*TAP_W-1:0] fan_tap(input logic [TAP_W-1:0] t);
    return {LANES{t}};
  endfunction

endpackage

// File: rtl/adc366x_win_find.sv
// Serial longest-run scanner: one bitmap bit per cycle, ties keep the lowest start.
// The start cycle itself consumes bit 0, so an N-bit map yields valid N cycles after start.
module adc366x_win_find
  import adc366x_pkg::*;
#(
  parameter int N = 32,
  parameter int W = TAP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] map,
  input  logic         start,
  output logic [W-1:0] best_start,
  output logic [W:0]   best_len,
  output logic         valid
);

  logic         scanning;
  logic [W-1:0] idx;
  logic [W-1:0] run_start;
  logic [W:0]   run_len;

  logic [W-1:0] n_idx;
  logic [W-1:0] n_rs;
  logic [W:0]   n_rl;
  logic [W-1:0] n_bs;
  logic [W:0]   n_bl;

  always_comb begin
    n_idx = start ? '0 : idx;
    n_rs  = start ? '0 : run_start;
    n_rl  = start ? '0 : run_len;
    n_bs  = start ? '0 : best_start;
    n_bl  = start ? '0 : best_len;
    if (map[n_idx]) begin
      if (n_rl == '0) n_rs = n_idx;
      n_rl = n_rl + 1'b1;
      if (n_rl > n_bl) begin
        n_bs = n_rs;
        n_bl = n_rl;
      end
    end else begin
      n_rl = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scanning   <= 1'b0;
      idx        <= '0;
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start || scanning) begin
        idx        <= n_idx + 1'b1;
        run_start  <= n_rs;
        run_len    <= n_rl;
        best_start <= n_bs;
        best_len   <= n_bl;
        scanning   <= (n_idx != W'(N-1));
        valid      <= (n_idx == W'(N-1));
      end
    end
  end

endmodule

// File: rtl/adc366x_dly_train.sv
// IDELAY calibration: sweeps a common tap, records pass/fail per tap against a
// fixed test pattern, then loads the centre of the widest passing window.
module adc366x_dly_train
  import adc366x_pkg::*;
#(
  parameter int TAPS    = 32,
  parameter int SETTLE  = 64,
  parameter int CHECK   = 256,
  parameter int MIN_WIN = 4
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic             start_i,
  input  logic [15:0]      pat_i,
  input  logic [31:0]      adc_dat_i,
  input  logic             adc_dv_i,
  output logic [DLY_W-1:0] dly_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [TAP_W-1:0] tap_o,
  output logic [TAP_W:0]   win_o,
  output logic [31:0]      map_o
);

  localparam int CW = $clog2(4*CHECK + SETTLE + 1);
  localparam int LW = TAP_W + 1;

  state_t           state, nxt;
  logic [TAP_W-1:0] tap;
  logic [CW-1:0]    cyc;
  logic [CW-1:0]    smp;
  logic             err;
  logic             mismatch, last_smp, timeout, tap_last;
  logic             win_go, win_valid, win_ok;
  logic [TAP_W-1:0] win_start, centre;
  logic [LW-1:0]    win_len;

  assign mismatch = (adc_dat_i[15:0] != pat_i) || (adc_dat_i[31:16] != pat_i);
  assign last_smp = adc_dv_i && (smp == CW'(CHECK-1));
  assign timeout  = (cyc == CW'(4*CHECK-1));
  assign tap_last = (tap == TAP_W'(TAPS-1));
  assign win_go   = (state == ST_NEXT) && tap_last;
  assign win_ok   = (win_len >= LW'(MIN_WIN));
  assign centre   = win_ok ? win_start + TAP_W'((win_len - 1'b1) >> 1) : '0;

  // Scanner starts in the final NEXT cycle: bit 0 is already settled there,
  // and the last tap's bit is written long before the scanner reaches it.
  adc366x_win_find #(
    .N(TAPS),
    .W(TAP_W)
  ) u_win (
    .clk       (adc_clk_i),
    .rst       (adc_rst_i),
    .map       (map_o[TAPS-1:0]),
    .start     (win_go),
    .best_start(win_start),
    .best_len  (win_len),
    .valid     (win_valid)
  );

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) state <= ST_IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start_i) nxt = ST_LOAD;
      ST_LOAD:   nxt = ST_SETTLE;
      ST_SETTLE: if (cyc == CW'(SETTLE-1)) nxt = ST_CHECK;
      ST_CHECK:  if (last_smp || timeout) nxt = ST_NEXT;
      ST_NEXT:   nxt = tap_last ? ST_EVAL : ST_LOAD;
      ST_EVAL:   if (win_valid) nxt = ST_APPLY;
      ST_APPLY:  nxt = ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      dly_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      fail_o <= 1'b0;
      tap_o  <= '0;
      win_o  <= '0;
      map_o  <= '0;
      tap    <= '0;
      cyc    <= '0;
      smp    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          map_o  <= '0;
          done_o <= 1'b0;
          fail_o <= 1'b0;
          win_o  <= '0;
          tap    <= '0;
          busy_o <= 1'b1;
        end
        ST_LOAD: begin
          dly_o <= {~dly_o[TGL_BIT], fan_tap(tap)};
          cyc   <= '0;
          smp   <= '0;
          err   <= 1'b0;
        end
        ST_SETTLE: cyc <= (cyc == CW'(SETTLE-1)) ? '0 : cyc + 1'b1;
        ST_CHECK: begin
          cyc <= cyc + 1'b1;
          if (adc_dv_i) begin
            smp <= smp + 1'b1;
            if (mismatch) err <= 1'b1;
          end
          if (timeout && !last_smp) err <= 1'b1;
        end
        ST_NEXT: begin
          map_o[tap] <= !err;
          if (!tap_last) tap <= tap + 1'b1;
        end
        ST_APPLY: begin
          tap_o  <= centre;
          fail_o <= !win_ok;
          win_o  <= win_len;
          dly_o  <= {~dly_o[TGL_BIT], fan_tap(centre)};
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc366x_dly_train.sv
// Randomised bench: receiver/ADC model drives data from the loaded tap, a
// scoreboard holds per-run expectations, and a monitor checks on each done.
module tb_adc366x_dly_train;

  localparam int TAPS    = 32;
  localparam int SETTLE  = 8;
  localparam int CHECK   = 16;
  localparam int MIN_WIN = 4;

  logic        adc_clk_i = 1'b0;
  logic        adc_rst_i;
  logic        start_i;
  logic [15:0] pat_i;
  logic [31:0] adc_dat_i;
  logic        adc_dv_i;
  logic [25:0] dly_o;
  logic        busy_o, done_o, fail_o;
  logic [4:0]  tap_o;
  logic [5:0]  win_o;
  logic [31:0] map_o;

  adc366x_dly_train #(
    .TAPS(TAPS), .SETTLE(SETTLE), .CHECK(CHECK), .MIN_WIN(MIN_WIN)
  ) dut (
    .adc_clk_i(adc_clk_i), .adc_rst_i(adc_rst_i), .start_i(start_i), .pat_i(pat_i),
    .adc_dat_i(adc_dat_i), .adc_dv_i(adc_dv_i), .dly_o(dly_o), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .tap_o(tap_o), .win_o(win_o), .map_o(map_o)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  typedef struct {
    logic [31:0] map;
    int          win;
    int          tap;
    bit          fail;
    int          dur;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pass_mask;
  int          dv_mode;
  bit          last_only;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [24:0] lanes(input int t);
    logic [24:0] r;
    for (int l = 0; l < 5; l++) r[5*l +: 5] = t[4:0];
    return r;
  endfunction

  // Longest all-ones interval by brute force over every (start, end) pair.
  task automatic model(input logic [31:0] m, output int bs, output int bl);
    bs = 0;
    bl = 0;
    for (int s = 0; s < TAPS; s++)
      for (int e = s; e < TAPS; e++) begin
        bit all;
        all = 1'b1;
        for (int k = s; k <= e; k++) if (!m[k]) all = 1'b0;
        if (all && (e - s + 1) > bl) begin
          bl = e - s + 1;
          bs = s;
        end
      end
  endtask

  task automatic expect_run(input logic [31:0] m, input int dvm);
    exp_t e;
    int bs, bl;
    e.map = (dvm == 0) ? 32'h0 : m;
    model(e.map, bs, bl);
    e.win  = bl;
    e.fail = (bl < MIN_WIN);
    e.tap  = e.fail ? 0 : bs + (bl - 1) / 2;
    if (dvm == 1)      e.dur = TAPS*(2 + SETTLE + CHECK) + TAPS + 1;
    else if (dvm == 0) e.dur = TAPS*(2 + SETTLE + 4*CHECK) + TAPS + 1;
    else               e.dur = -1;
    sb.push_back(e);
  endtask

  // ADC + receiver model: data quality follows the most recently loaded tap.
  initial begin : rx_model
    logic        prev;
    int          since;
    logic [4:0]  cur;
    logic [31:0] d;
    int          lane, b;
    prev = 1'b0; since = 0; cur = '0;
    adc_dat_i = '0; adc_dv_i = 1'b0;
    forever begin
      @(posedge adc_clk_i); #2;
      if (adc_rst_i) begin
        prev = 1'b0; since = 0;
      end else if (dly_o[25] != prev) begin
        prev = dly_o[25]; cur = dly_o[4:0]; since = 0;
      end else begin
        since++;
      end
      case (dv_mode)
        0:       adc_dv_i = 1'b0;
        1:       adc_dv_i = 1'b1;
        default: adc_dv_i = ($urandom_range(0, 3) != 0);
      endcase
      d = {pat_i, pat_i};
      if (!adc_dv_i) d = $urandom();
      else if (!pass_mask[cur] && (!last_only || since == SETTLE + CHECK - 1)) begin
        lane = $urandom_range(0, 2);
        b    = $urandom_range(0, 15);
        if (lane != 1) d[b] = ~d[b];
        if (lane != 0) d[16+b] = ~d[16+b];
      end
      adc_dat_i = d;
    end
  end

  initial begin : monitor
    logic pt, pd, pb;
    int   tg, bc;
    exp_t e;
    pt = 1'b0; pd = 1'b0; pb = 1'b0; tg = 0; bc = 0;
    forever begin
      @(negedge adc_clk_i);
      if (adc_rst_i) begin
        pt = 1'b0; pd = 1'b0; pb = 1'b0; tg = 0; bc = 0;
      end else begin
        if (busy_o && !pb) begin tg = 0; bc = 0; end
        if (busy_o) bc++;
        if (dly_o[25] != pt) begin
          pt = dly_o[25];
          tg++;
          if (tg <= TAPS) chk("sweep_tap", dly_o[24:0], lanes(tg - 1));
        end
        if (done_o && !pd) begin
          chk("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("map", map_o, e.map);
            chk("win", win_o, e.win);
            chk("tap", tap_o, e.tap);
            chk("fail", fail_o, e.fail);
            chk("dly_apply", dly_o[24:0], lanes(e.tap));
            chk("toggle_count", tg, TAPS + 1);
            chk("busy_at_done", busy_o, 0);
            if (e.dur >= 0) chk("duration", bc, e.dur);
          end
        end
        pd = done_o;
        pb = busy_o;
      end
    end
  end

  task automatic run(input logic [31:0] m, input int dvm, input bit lo,
                     input bit noise, input bit late_start);
    int n;
    @(posedge adc_clk_i); #1;
    pass_mask = m; dv_mode = dvm; last_only = lo;
    pat_i = 16'($urandom());
    expect_run(m, dvm);
    start_i = 1'b1;
    @(posedge adc_clk_i); #1;
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1);
    chk("clr_done", done_o, 0);
    chk("clr_map", map_o, 0);
    chk("clr_win", win_o, 0);
    chk("clr_fail", fail_o, 0);
    n = 0;
    while (!done_o && n < 20000) begin
      start_i = noise && ($urandom_range(0, 63) == 0);
      @(posedge adc_clk_i); #1;
      n++;
    end
    start_i = 1'b0;
    chk("done_in_time", done_o, 1);
    if (!done_o) begin
      adc_rst_i = 1'b1;
      @(posedge adc_clk_i); #1;
      adc_rst_i = 1'b0;
      sb.delete();
    end else if (late_start) begin
      start_i = 1'b1;
      @(posedge adc_clk_i); #1;
      start_i = 1'b0;
      @(posedge adc_clk_i); #1;
      chk("late_start_ignored", busy_o, 0);
      chk("done_sticky", done_o, 1);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n;
    logic [31:0] m;
    int lo_bit, len;
    adc_rst_i = 1'b1; start_i = 1'b0; pat_i = '0;
    pass_mask = '0; dv_mode = 1; last_only = 1'b0;
    repeat (3) @(posedge adc_clk_i);
    @(negedge adc_clk_i);
    chk("rst_dly", dly_o, 0);
    chk("rst_flags", {busy_o, done_o, fail_o}, 0);
    chk("rst_tap_win", {tap_o, win_o}, 0);
    chk("rst_map", map_o, 0);
    @(posedge adc_clk_i); #1;
    adc_rst_i = 1'b0;

    run(32'h000F_FC00, 1, 1'b1, 1'b0, 1'b0);
    run(32'h03F0_00FC, 2, 1'b0, 1'b0, 1'b0);
    run(32'hC000_0000, 2, 1'b0, 1'b0, 1'b1);
    run($urandom(),    0, 1'b0, 1'b0, 1'b0);

    // Abort a sweep during the CHECK phase of tap 7.
    @(posedge adc_clk_i); #1;
    pass_mask = 32'h00FF_FF00; dv_mode = 2; last_only = 1'b0;
    start_i = 1'b1;
    @(posedge adc_clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (!(busy_o && dly_o[4:0] == 5'd7) && n < 5000) begin
      @(posedge adc_clk_i); #1;
      n++;
    end
    chk("reach_tap7", dly_o[4:0], 7);
    repeat (SETTLE + 3) @(posedge adc_clk_i);
    #1 adc_rst_i = 1'b1;
    @(negedge adc_clk_i);
    chk("midrst_dly", dly_o, 0);
    chk("midrst_flags", {busy_o, done_o, fail_o}, 0);
    chk("midrst_tap_win", {tap_o, win_o}, 0);
    chk("midrst_map", map_o, 0);
    @(posedge adc_clk_i); #1;
    adc_rst_i = 1'b0;
    run(32'h000F_FC00, 2, 1'b0, 1'b0, 1'b0);

    run(32'h0FF0_F0F0, 2, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      m = $urandom() & $urandom();
      lo_bit = $urandom_range(0, 31);
      len = $urandom_range(0, 12);
      for (int k = 0; k < len; k++) if (lo_bit + k < 32) m[lo_bit + k] = 1'b1;
      if (r % 2 == 0) run(m, 1, 1'b1, 1'b0, 1'b0);
      else            run(m, 2, 1'b0, 1'b1, 1'b0);
    end

    repeat (5) @(posedge adc_clk_i);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
